// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the downstream sequence detectors:
// state encoding, counter widths and a constant clog2 helper.
package serial_bit_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam int unsigned GapCntW = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << result) < 64'(value)) begin
        result++;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word handshake into the feeder and serial bit stream out of it.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             frame_done;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, frame_done, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, frame_done, busy
  );
endinterface

// File: rtl/serial_bit_feeder_load_down_counter.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
module serial_bit_feeder_load_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words onto a single bit stream for the sequence detectors, with
// optional idle gap between words and zero-bubble back-to-back transfers when no gap is set.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic                clk,
  input logic                rst,
  serial_bit_feeder_if.slave bus
);

  localparam int unsigned         BitCntW = clog2(WIDTH);
  localparam bit                  HasGap  = (GAP_CYCLES > 0);
  localparam logic [BitCntW-1:0]  BitLoad = BitCntW'(WIDTH - 1);
  localparam logic [GapCntW-1:0]  GapLoad = HasGap ? GapCntW'(GAP_CYCLES - 1) : '0;

  state_e           state_d, state_q;
  logic [WIDTH-1:0] sreg_d, sreg_q;
  logic             x_d, x_q;
  logic             x_valid_d, x_valid_q;
  logic             frame_done_d, frame_done_q;
  logic             busy_d, busy_q;

  logic               bit_load, bit_en, bit_zero;
  logic [BitCntW-1:0] bit_cnt;
  logic               gap_load, gap_en, gap_zero;
  logic [GapCntW-1:0] gap_cnt;
  logic               din_ready, xfer;

  serial_bit_feeder_load_down_counter #(
    .Width (BitCntW)
  ) u_bit_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (bit_load),
    .load_val_i (BitLoad),
    .en_i       (bit_en),
    .count_o    (bit_cnt),
    .zero_o     (bit_zero)
  );

  serial_bit_feeder_load_down_counter #(
    .Width (GapCntW)
  ) u_gap_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (gap_load),
    .load_val_i (GapLoad),
    .en_i       (gap_en),
    .count_o    (gap_cnt),
    .zero_o     (gap_zero)
  );

  logic unused_gap_cnt;
  assign unused_gap_cnt = ^gap_cnt;

  // Ready on the last bit only without a gap, so the next word follows with no bubble.
  assign din_ready = (state_q == StIdle) || (!HasGap && (state_q == StShift) && bit_zero);
  assign xfer      = bus.din_valid && din_ready;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bit_load = 1'b0;
    bit_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          sreg_d   = bus.din;
          bit_load = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (!bit_zero) begin
          sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          bit_en = 1'b1;
        end else if (HasGap) begin
          sreg_d   = '0;
          gap_load = 1'b1;
          state_d  = StGap;
        end else if (xfer) begin
          sreg_d   = bus.din;
          bit_load = 1'b1;
        end else begin
          sreg_d  = '0;
          state_d = StIdle;
        end
      end
      StGap: begin
        gap_en = 1'b1;
        if (gap_zero) begin
          state_d = StIdle;
        end
      end
      default: begin
        sreg_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from next state, so they line up with state_q/sreg_q.
  always_comb begin
    x_valid_d    = (state_d == StShift);
    x_d          = x_valid_d && (MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0]);
    frame_done_d = bit_en && (bit_cnt == BitCntW'(1));
    busy_d       = (state_d == StShift) || (state_d == StGap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sreg_q       <= '0;
      x_q          <= 1'b0;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule
